// File: rtl/interleaver_pkg.sv
// Shared definitions for the interleaver block scheduler: FSM encoding and
// counter-width helpers derived from the block geometry.
package interleaver_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    XFER = 2'd1,
    PAD  = 2'd2
  } sched_state_t;

  // $clog2 with a floor of one bit so degenerate parameters still give legal vectors
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned beat_cnt_w(input int unsigned cw_size);
    return width_of(cw_size);
  endfunction

  function automatic int unsigned pad_rem_w(input int unsigned cw_size, input int unsigned num_cw);
    return width_of(cw_size * num_cw + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from ptr+1.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!gnt_any && req[j] && (j == (32'(ptr) + i) % N)) begin
          gnt_any   = 1'b1;
          gnt_oh[j] = 1'b1;
          gnt_idx   = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/interleaver_block_scheduler.sv
// Grants whole codewords from NUM_SRC AXIS sources to the interleaver and pads
// a partial block with zero beats once the sources have gone idle.
module interleaver_block_scheduler
  import interleaver_pkg::*;
#(
  parameter int unsigned CODEWORD_SIZE_IN_32 = 65,
  parameter int unsigned NUM_CODEWORDS       = 4,
  parameter int unsigned NUM_SRC             = 2,
  parameter int unsigned FLUSH_TIMEOUT       = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*32-1:0]         s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [31:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [width_of(NUM_SRC)-1:0]  m_axis_tuser,
  output logic                          m_axis_tpad,
  output logic [15:0]                   blocks_done,
  output logic [15:0]                   pads_done
);

  localparam int unsigned IW   = width_of(NUM_SRC);
  localparam int unsigned BW   = beat_cnt_w(CODEWORD_SIZE_IN_32);
  localparam int unsigned RW   = pad_rem_w(CODEWORD_SIZE_IN_32, NUM_CODEWORDS);
  localparam int unsigned CW_W = width_of(NUM_CODEWORDS);
  localparam int unsigned TM_W = width_of(FLUSH_TIMEOUT);

  sched_state_t        state, state_nxt;
  logic [IW-1:0]       grant, rr_ptr;
  logic [NUM_SRC-1:0]  grant_oh;
  logic [BW-1:0]       beat_cnt;
  logic [CW_W-1:0]     cw_cnt;
  logic [TM_W-1:0]     timer;
  logic [RW-1:0]       pad_rem;

  logic [NUM_SRC-1:0]  arb_oh;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [31:0]         sel_data;
  logic                sel_valid;
  logic                xfer_hs, cw_last, pad_last, timeout;

  rr_arbiter #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_arb (
    .req     (s_axis_tvalid),
    .ptr     (rr_ptr),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_oh[i]) begin
        sel_data  = s_axis_tdata[32*i +: 32];
        sel_valid = s_axis_tvalid[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    xfer_hs       = 1'b0;
    cw_last       = 1'b0;
    pad_last      = 1'b0;
    timeout       = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tpad   = 1'b0;
    m_axis_tuser  = '0;
    s_axis_tready = '0;
    unique case (state)
      ARB: begin
        // a requester present on the timeout cycle takes priority over padding
        if (arb_any) begin
          state_nxt = XFER;
        end else if (cw_cnt != '0 && timer == TM_W'(FLUSH_TIMEOUT - 1)) begin
          state_nxt = PAD;
          timeout   = 1'b1;
        end
      end
      XFER: begin
        m_axis_tvalid = sel_valid;
        m_axis_tdata  = sel_data;
        m_axis_tuser  = grant;
        s_axis_tready = grant_oh & {NUM_SRC{m_axis_tready}};
        xfer_hs       = sel_valid & m_axis_tready;
        if (xfer_hs && beat_cnt == BW'(CODEWORD_SIZE_IN_32 - 1)) begin
          cw_last   = 1'b1;
          state_nxt = ARB;
        end
      end
      PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tpad   = 1'b1;
        if (m_axis_tready && pad_rem == RW'(1)) begin
          pad_last  = 1'b1;
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_oh    <= '0;
      rr_ptr      <= IW'(NUM_SRC - 1);
      beat_cnt    <= '0;
      cw_cnt      <= '0;
      timer       <= '0;
      pad_rem     <= '0;
      blocks_done <= '0;
      pads_done   <= '0;
    end else begin
      unique case (state)
        ARB: begin
          if (arb_any) begin
            grant    <= arb_idx;
            grant_oh <= arb_oh;
            beat_cnt <= '0;
            timer    <= '0;
          end else if (timeout) begin
            pad_rem <= RW'((NUM_CODEWORDS - 32'(cw_cnt)) * CODEWORD_SIZE_IN_32);
            timer   <= '0;
          end else if (cw_cnt != '0) begin
            timer <= timer + TM_W'(1);
          end else begin
            timer <= '0;
          end
        end
        XFER: begin
          if (xfer_hs) begin
            if (cw_last) begin
              beat_cnt <= '0;
              rr_ptr   <= grant;
              if (cw_cnt == CW_W'(NUM_CODEWORDS - 1)) begin
                cw_cnt      <= '0;
                blocks_done <= blocks_done + 16'd1;
              end else begin
                cw_cnt <= cw_cnt + CW_W'(1);
              end
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        PAD: begin
          if (m_axis_tready) begin
            if (pad_last) begin
              cw_cnt      <= '0;
              blocks_done <= blocks_done + 16'd1;
              pads_done   <= pads_done + 16'd1;
            end else begin
              pad_rem <= pad_rem - RW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_interleaver_block_scheduler.sv
// Scoreboard bench: directed scenarios push expected beats, a negedge monitor
// pops and compares every accepted output beat.
module tb_interleaver_block_scheduler;

  localparam int unsigned CW = 65;
  localparam int unsigned NC = 4;
  localparam int unsigned NS = 2;
  localparam int unsigned FT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NS*32-1:0] s_axis_tdata;
  logic [NS-1:0]    s_axis_tvalid;
  logic [NS-1:0]    s_axis_tready;
  logic [31:0]      m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [0:0]       m_axis_tuser;
  logic             m_axis_tpad;
  logic [15:0]      blocks_done;
  logic [15:0]      pads_done;

  always #5 clk = ~clk;

  interleaver_block_scheduler #(
    .CODEWORD_SIZE_IN_32 (CW),
    .NUM_CODEWORDS       (NC),
    .NUM_SRC             (NS),
    .FLUSH_TIMEOUT       (FT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tpad   (m_axis_tpad),
    .blocks_done   (blocks_done),
    .pads_done     (pads_done)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        p;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cnt[NS];
  int unsigned lim[NS];
  bit          gap_mode   = 1'b0;
  bit          rand_ready = 1'b0;
  int          idle_cnt   = 0;

  function automatic logic [31:0] src_word(input int unsigned s, input int unsigned n);
    return {8'hA0 + 8'(s), 8'h5A, 16'(n)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_cw(input int unsigned s, input int unsigned first, input int unsigned nb);
    for (int unsigned k = 0; k < nb; k++)
      exp_q.push_back('{d: src_word(s, first + k), u: 1'(s), p: 1'b0});
  endtask

  task automatic push_pad(input int unsigned nb);
    for (int unsigned k = 0; k < nb; k++)
      exp_q.push_back('{d: 32'h0, u: 1'b0, p: 1'b1});
  endtask

  // gaps only appear inside a codeword so arbitration order stays predictable
  task automatic drive();
    for (int unsigned i = 0; i < NS; i++) begin
      s_axis_tvalid[i] = (cnt[i] < lim[i]) &&
                         (!gap_mode || (cnt[i] % CW) == 0 || $urandom_range(0, 1) == 1);
      s_axis_tdata[32*i +: 32] = src_word(i, cnt[i]);
    end
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic step();
    logic [NS-1:0] hs;
    @(negedge clk);
    hs = rst ? '0 : (s_axis_tvalid & s_axis_tready);
    if (!rst && !m_axis_tvalid) idle_cnt++;
    @(posedge clk);
    #1;
    for (int unsigned i = 0; i < NS; i++)
      if (hs[i]) cnt[i]++;
    drive();
  endtask

  task automatic do_reset(input int unsigned l0, input int unsigned l1);
    rst = 1'b1;
    step();
    step();
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_tpad",   64'(m_axis_tpad),   64'd0);
    check("rst_tuser",  64'(m_axis_tuser),  64'd0);
    check("rst_tdata",  64'(m_axis_tdata),  64'd0);
    check("rst_blocks", 64'(blocks_done),   64'd0);
    check("rst_pads",   64'(pads_done),     64'd0);
    check("leftover_expect", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    cnt[0] = 0;
    cnt[1] = 0;
    lim[0] = l0;
    lim[1] = l1;
    idle_cnt = 0;
    rst = 1'b0;
    drive();
  endtask

  task automatic wait_empty(input int unsigned budget);
    int unsigned k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check("drain_within_budget", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : monitor
    beat_t e;
    bit    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("pad_hold_under_backpressure",
                64'({m_axis_tvalid, m_axis_tpad, m_axis_tdata}), {30'd0, 1'b1, 1'b1, 32'h0});
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: actual data %0h user %0d pad %0d, required no beat",
                     m_axis_tdata, m_axis_tuser, m_axis_tpad);
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'({m_axis_tdata, m_axis_tuser, m_axis_tpad}), 64'(e));
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready && m_axis_tpad;
      end
    end
  end

  initial begin : main
    cnt[0] = 0; cnt[1] = 0;
    lim[0] = 0; lim[1] = 0;
    drive();

    // both sources saturated: 0,1,0,1 back to back, one ARB cycle per codeword
    do_reset(2*CW, 2*CW);
    push_cw(0, 0, CW);  push_cw(1, 0, CW);
    push_cw(0, CW, CW); push_cw(1, CW, CW);
    repeat (4*(CW+1)) step();
    #1;
    check("t1_drained", 64'(exp_q.size()), 64'd0);
    check("t1_blocks",  64'(blocks_done),  64'd1);
    check("t1_pads",    64'(pads_done),    64'd0);
    check("t1_idle",    64'(idle_cnt),     64'd4);

    // one codeword then silence: 16 idle ARB cycles, then 195 pad beats
    do_reset(CW, 0);
    push_cw(0, 0, CW);
    push_pad((NC-1)*CW);
    repeat (1 + CW + FT + (NC-1)*CW) step();
    #1;
    check("t2_drained", 64'(exp_q.size()), 64'd0);
    check("t2_pads",    64'(pads_done),    64'd1);
    check("t2_blocks",  64'(blocks_done),  64'd1);
    check("t2_idle",    64'(idle_cnt),     64'd17);

    // random backpressure and mid-codeword valid gaps
    do_reset(2*CW, 2*CW);
    gap_mode   = 1'b1;
    rand_ready = 1'b1;
    push_cw(0, 0, CW);  push_cw(1, 0, CW);
    push_cw(0, CW, CW); push_cw(1, CW, CW);
    wait_empty(6000);
    step(); step();
    #1;
    check("t3_blocks", 64'(blocks_done), 64'd1);
    check("t3_pads",   64'(pads_done),   64'd0);
    gap_mode   = 1'b0;
    rand_ready = 1'b0;

    // source 1 wakes exactly on the timer==15 cycle: it wins, no padding
    do_reset(CW, 0);
    push_cw(0, 0, CW);
    push_cw(1, 0, CW);
    for (int c = 0; c < 2*CW + FT + 1; c++) begin
      if (c == CW + FT - 1) lim[1] = CW;
      step();
    end
    #1;
    check("t4_drained", 64'(exp_q.size()), 64'd0);
    check("t4_pads",    64'(pads_done),    64'd0);
    check("t4_blocks",  64'(blocks_done),  64'd0);

    // reset at beat 30 of codeword 2, then restart from source 0 with cw_cnt 0
    do_reset(160, 130);
    push_cw(0, 0, CW);  push_cw(1, 0, CW);
    push_cw(0, CW, 30);
    push_cw(0, 95, CW); push_cw(1, CW, CW);
    push_pad(2*CW);
    for (int c = 0; c < 164; c++) begin
      step();
      if (c == 162) rst = 1'b1;
      if (c == 163) rst = 1'b0;
    end
    #1;
    check("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t5_tready", 64'(s_axis_tready), 64'd0);
    check("t5_tpad",   64'(m_axis_tpad),   64'd0);
    check("t5_tuser",  64'(m_axis_tuser),  64'd0);
    check("t5_tdata",  64'(m_axis_tdata),  64'd0);
    check("t5_blocks_cleared", 64'(blocks_done), 64'd0);
    rand_ready = 1'b1;
    wait_empty(4000);
    rand_ready = 1'b0;
    step(); step();
    #1;
    check("t5_pads",   64'(pads_done),   64'd1);
    check("t5_blocks", 64'(blocks_done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interleaver_block_scheduler.md
INTERLEAVER_BLOCK_SCHEDULER -- requirements
Module: interleaver_block_scheduler

Interface
REQ-001 SHALL have parameter CODEWORD_SIZE_IN_32, default 65, meaning 32-bit beats per codeword.
REQ-002 SHALL have parameter NUM_CODEWORDS, default 4, meaning codewords per interleaver block.
REQ-003 SHALL have parameter NUM_SRC, default 2, meaning number of requesting AXIS sources.
REQ-004 SHALL have parameter FLUSH_TIMEOUT, default 1024, meaning idle cycles before a partial block is padded.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port s_axis_tdata  input  NUM_SRC*32  source i data in bits [32*i+31:32*i].
REQ-008 SHALL have port s_axis_tvalid  input  NUM_SRC  per-source valid.
REQ-009 SHALL have port s_axis_tready  output  NUM_SRC  per-source ready.
REQ-010 SHALL have port m_axis_tdata  output  32  data to interleaver slave port.
REQ-011 SHALL have port m_axis_tvalid  output  1  valid to interleaver.
REQ-012 SHALL have port m_axis_tready  input  1  ready from interleaver.
REQ-013 SHALL have port m_axis_tuser  output  $clog2(NUM_SRC)  source index of current beat; 0 during padding.
REQ-014 SHALL have port m_axis_tpad  output  1  high on padding beats.
REQ-015 SHALL have port blocks_done  output  16  completed-block count, wraps at 2^16.
REQ-016 SHALL have port pads_done  output  16  padded-block count, wraps at 2^16.

Function
REQ-017 SHALL implement FSM states ARB, XFER, PAD; ARB after reset.
REQ-018 ARB: all s_axis_tready=0, m_axis_tvalid=0; if any tvalid set, grant first valid source searching upward from rr_ptr+1 (mod NUM_SRC), register grant, go XFER next cycle.
REQ-019 XFER: m_axis_tdata/tvalid pass granted source combinationally; s_axis_tready[grant]=m_axis_tready, all others 0; zero added latency per beat.
REQ-020 Grant SHALL be held for exactly CODEWORD_SIZE_IN_32 handshakes; no preemption, tvalid gaps tolerated.
REQ-021 On last beat of a codeword: rr_ptr<=grant; cw_cnt increments, or wraps to 0 with blocks_done+1 when cw_cnt==NUM_CODEWORDS-1; next state ARB.
REQ-022 Idle timer counts ARB cycles with cw_cnt!=0 and no tvalid; cleared on any grant or when cw_cnt==0.
REQ-023 Timer reaching FLUSH_TIMEOUT-1 SHALL enter PAD; a valid source in that same cycle wins (grant, no pad).
REQ-024 PAD: m_axis_tvalid=1, m_axis_tdata=0, m_axis_tpad=1, s_axis_tready=0; emits (NUM_CODEWORDS-cw_cnt)*CODEWORD_SIZE_IN_32 beats on m_axis_tready handshakes.
REQ-025 PAD end: cw_cnt<=0, blocks_done+1, pads_done+1, state ARB; rr_ptr unchanged.
REQ-026 m_axis_tdata and m_axis_tvalid SHALL not change while m_axis_tvalid=1 and m_axis_tready=0 in PAD.
REQ-027 Beat counter width $clog2(CODEWORD_SIZE_IN_32); block beat remainder width $clog2(CODEWORD_SIZE_IN_32*NUM_CODEWORDS+1).
REQ-028 NUM_SRC=1 SHALL work: tuser width forced to 1, constant 0.

Reset
REQ-029 rst SHALL set state ARB, cw_cnt 0, beat counter 0, timer 0, rr_ptr NUM_SRC-1 (source 0 first), grant 0, blocks_done 0, pads_done 0.
REQ-030 Outputs after reset: m_axis_tvalid 0, s_axis_tready all 0, m_axis_tpad 0, m_axis_tuser 0, m_axis_tdata 0.
REQ-031 rst mid-codeword SHALL abandon the partial codeword; the interleaver SHALL share the same rst so block alignment is restored.

Structure
REQ-032 State encoding localparams and counter widths SHALL live in shared package interleaver_pkg.
REQ-033 Round-robin selection SHALL be sub-module rr_arbiter (req, ptr in; one-hot and index grant out, combinational).

Verification
REQ-034 Bench params CODEWORD_SIZE_IN_32=65, NUM_CODEWORDS=4, NUM_SRC=2, FLUSH_TIMEOUT=16.
REQ-035 Both sources always valid, ready=1 -> tuser 0,1,0,1 per 65-beat codeword; blocks_done=1 after 260 beats, no bubbles inside a codeword.
REQ-036 Source 0 sends one codeword then stops -> after 16 idle ARB cycles, 195 zero beats with tpad=1; pads_done=1, blocks_done=1.
REQ-037 Random m_axis_tready (50%) and source tvalid gaps -> every codeword delivered intact, in-order, 65 beats, never interleaved between sources.
REQ-038 Source 1 asserts tvalid on the timeout cycle (timer=15) -> grant to 1, no pad, pads_done=0.
REQ-039 rst asserted at beat 30 of codeword 2 -> next cycle state ARB, all outputs at reset values, following stream starts at source 0, cw_cnt 0.
